// File: rtl/down_counter_if.sv
// Control/status bundle for the loadable down-counting timer.
// The timer side uses the slave modport; the driving logic uses master.
interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             mode;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, data, mode, en,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, data, mode, en,
        output count, tc, busy, done
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counting timer with one-shot and auto-reload modes.
// Optional tick prescaler is built only when DOWN_COUNTER_PRESCALE_EN is defined.
//
//   state | meaning
//   IDLE  | reset state, or loaded with zero; ticks ignored
//   RUN   | counting down on ticks
//   PAUSE | running but enable low; count held
//   DONE  | one-shot expired; count held at zero
module down_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst,
    down_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("down_counter: PRESCALE must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q, psc_d;

    always_comb begin
        psc_d = psc_q;
        tick  = 1'b0;
        if (bus.load) begin
            psc_d = '0;
        end else if (bus.en) begin
            if (psc_q == PSC_LAST) begin
                psc_d = '0;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign tick = bus.en;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;

        if (bus.load) begin
            // Load wins over any tick, including a terminal one.
            count_d  = bus.data;
            reload_d = bus.data;
            mode_d   = bus.mode;
            state_d  = (bus.data != '0) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN, PAUSE: begin
                    if (tick) begin
                        state_d = RUN;
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - 1'b1;
                        end else if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (mode_q) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                        // count_q == 0 cannot be reached here; holding keeps it from wrapping.
                    end else if (state_q == RUN) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = bus.en ? RUN : PAUSE;
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
    assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter.
// Prescaler checks run only when DOWN_COUNTER_PRESCALE_EN is defined.
module tb_down_counter;

    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;
    int   tc_seen;

    down_counter_if #(.WIDTH(WIDTH)) bus ();

    down_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle so outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] d, input logic m);
        bus.load = 1'b1;
        bus.data = d;
        bus.mode = m;
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.mode  = 1'b0;
        bus.en    = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_tc",    32'(bus.tc),    0);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_done",  32'(bus.done),  0);
        rst = 1'b1;

        // One-shot, N=10
        bus.en = 1'b1;
        do_load(8'd10, 1'b0);
        chk("os_load_count", 32'(bus.count), 10);
        chk("os_load_busy",  32'(bus.busy),  1);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("os_count", 32'(bus.count), 32'(10 - k));
            chk("os_tc",    32'(bus.tc),    (k == 10) ? 1 : 0);
            chk("os_busy",  32'(bus.busy),  (k == 10) ? 0 : 1);
            chk("os_done",  32'(bus.done),  (k == 10) ? 1 : 0);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            chk("os_hold", {bus.count, 21'd0, bus.tc, bus.busy, bus.done}, 32'h0000_0001);
        end

        // Auto-reload, N=3, 12 cycles
        do_load(8'd3, 1'b1);
        chk("ar_load_count", 32'(bus.count), 3);
        tc_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("ar_count", 32'(bus.count), (k % 3 == 0) ? 3 : 32'(3 - (k % 3)));
            chk("ar_tc",    32'(bus.tc),    (k % 3 == 0) ? 1 : 0);
            if (bus.tc) tc_seen++;
        end
        chk("ar_tc_pulses", 32'(tc_seen), 4);

        // Pause at count 3 for 4 cycles
        do_load(8'd5, 1'b0);
        step();
        step();
        chk("pz_pre", 32'(bus.count), 3);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("pz_count", 32'(bus.count), 3);
            chk("pz_busy",  32'(bus.busy),  1);
            chk("pz_tc",    32'(bus.tc),    0);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("pz_resume_count", 32'(bus.count), 32'(3 - k));
            chk("pz_resume_tc",    32'(bus.tc),    (k == 3) ? 1 : 0);
        end

        // Zero load lands in IDLE
        do_load(8'd0, 1'b0);
        chk("z_busy",  32'(bus.busy),  0);
        chk("z_done",  32'(bus.done),  0);
        chk("z_count", 32'(bus.count), 0);
        step();
        chk("z_tc",    32'(bus.tc),    0);
        chk("z_busy2", 32'(bus.busy),  0);

        // Load in the terminal cycle
        do_load(8'd2, 1'b0);
        step();
        chk("lt_pre", 32'(bus.count), 1);
        do_load(8'd7, 1'b0);
        chk("lt_tc",    32'(bus.tc),    0);
        chk("lt_count", 32'(bus.count), 7);
        chk("lt_busy",  32'(bus.busy),  1);

        // Full-range load counts down by one
        do_load(8'd255, 1'b1);
        step();
        chk("fr_count", 32'(bus.count), 254);

        // Async reset between edges
        do_load(8'd6, 1'b0);
        step();
        step();
        chk("ar_pre", 32'(bus.count), 4);
        #2 rst = 1'b0;
        #1;
        chk("async_count", 32'(bus.count), 0);
        chk("async_busy",  32'(bus.busy),  0);
        #1 rst = 1'b1;
        step();
        chk("async_after_count", 32'(bus.count), 0);
        chk("async_after_busy",  32'(bus.busy),  0);

`ifdef DOWN_COUNTER_PRESCALE_EN
        // Prescaler 4, N=2
        do_load(8'd2, 1'b0);
        chk("ps_load", 32'(bus.count), 2);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("ps_count", 32'(bus.count), 32'(2 - k / 4));
            chk("ps_tc",    32'(bus.tc),    (k == 8) ? 1 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counting timer for the counter library, counting in the opposite direction to the loadable up-counter. It loads a start value, decrements on each enabled tick, and flags terminal count. It supports one-shot and auto-reload modes and serves as a programmable delay/period generator next to the up-counter in the same designs.

## Interface
- `WIDTH`, 8: counter and data width in bits.
- `PRESCALE`, 4: tick divider ratio, ≥1. Only used when `DOWN_COUNTER_PRESCALE_EN` is defined.

- `clk` input 1: clock. All state is updated on the rising edge.
- `rst` input 1: asynchronous, active-low reset. `rst`=0 resets all state immediately.
- `load` input 1: loads `data` and `mode` on this edge. Has priority over all other activity.
- `data` input WIDTH: start/reload value, sampled when `load`=1.
- `mode` input 1: 0 = one-shot, 1 = auto-reload. Sampled only when `load`=1.
- `en` input 1: count enable (tick source).
- `count` output WIDTH: current counter value, registered.
- `tc` output 1: terminal-count pulse, one cycle wide, registered.
- `busy` output 1: high in RUN and PAUSE.
- `done` output 1: high in DONE (one-shot expired).

## Operation
- States:
  - IDLE: reset state and zero-load state.
  - RUN: counting.
  - PAUSE: running but `en`=0.
  - DONE: one-shot finished.
- Internal state: `reload` register (WIDTH bits) and latched `mode_q`.
- Reset values: `count`=0, `tc`=0, `busy`=0, `done`=0, `reload`=0, `mode_q`=0, state IDLE, prescale counter 0.
- `load`=1, from any state:
  - `count`←`data`, `reload`←`data`, `mode_q`←`mode`, `tc`←0, `done`←0.
  - Next state is RUN if `data`≠0, else IDLE.
  - Any tick in the same cycle is ignored.
- RUN:
  - If `tick`=0, go to PAUSE and hold `count`.
  - If `tick`=1 and `count`>1, `count`←`count`−1.
  - If `tick`=1 and `count`==1 and `mode_q`=0: `count`←0, `tc`←1, go to DONE.
  - If `tick`=1 and `count`==1 and `mode_q`=1: `count`←`reload`, `tc`←1, stay in RUN.
- PAUSE: hold `count`. Return to RUN on the first cycle with `en`=1; that cycle's tick is processed as in RUN.
- DONE: `count` holds 0 and `done`=1. Stay until `load`.
- IDLE: `count` holds its value. Ticks are ignored.
- `tc` is high only in the cycle after the terminal edge and 0 otherwise.
- Width rule: `count` never underflows. It never goes below 0 and never wraps to 2^WIDTH−1.
- `data`=2^WIDTH−1 is legal: a full-range period.

## Timing
- Load latency: `count`=`data` is visible after the load edge (edge L).
- First decrement: at edge L+1, if a tick occurs.
- One-shot with `en` held high and `data`=N (N≥1), after edge L+k:
  - `count` = N−k.
  - At k=N: `count`=0, `tc`=1, `busy`=0, `done`=1, all changing together.
  - At k=N+1: `tc`=0.
- Auto-reload with `en` high: `tc` pulses every N cycles. The first pulse is after edge L+N. The `count` sequence is N, N−1, …, 1, N, … and 0 is never shown.
- `busy` goes high after edge L when `data`≠0.
- Reset mid-count: outputs return to reset values asynchronously, without waiting for `clk`. Counting resumes only after a new `load`.
- `load` in the terminal cycle suppresses `tc` (load wins).

## Configuration
- Macro: `DOWN_COUNTER_PRESCALE_EN`.
- Defined:
  - An internal prescale counter (width $clog2(PRESCALE), min 1) advances on cycles with `en`=1.
  - `tick`=1 once every PRESCALE enabled cycles.
  - The prescale counter clears on `load` and on reset, and holds while `en`=0.
  - Decrement interval becomes PRESCALE enabled cycles. All other timing scales accordingly; the load latency is unchanged.
  - PRESCALE=1 behaves identically to the macro being undefined.
- Undefined: `tick`=`en`. No prescaler logic is built and `PRESCALE` is ignored.

## Test plan
- Reset then one-shot:
  - Stimulus: pulse `rst` low; `load`, `data`=8'd10, `mode`=0, `en`=1.
  - Response: `count` goes 10→0 over 10 cycles; `tc` is high for exactly 1 cycle at `count`=0; `done`=1 and `busy`=0 afterwards, and these hold for 20 more cycles.
- Auto-reload:
  - Stimulus: `load` `data`=8'd3, `mode`=1, `en`=1 for 12 cycles.
  - Response: `count` runs 3,2,1,3,2,1,…; `tc` pulses every 3 cycles, 4 pulses total; `count` never reads 0.
- Pause:
  - Stimulus: `data`=8'd5; drop `en` for 4 cycles when `count`=3.
  - Response: `count` holds 3 and `busy`=1 during the pause; after `en` rises, `tc` arrives 3 ticks later.
- Load edge cases:
  - Stimulus: `load` with `data`=0.
  - Response: state IDLE, `busy`=0, no `tc`.
  - Stimulus: `load` `data`=8'd7 in the cycle `count`==1 would expire.
  - Response: no `tc`; `count`=7.
- Async reset mid-count:
  - Stimulus: `rst` low between clock edges while `count`=4.
  - Response: `count`=0 and `busy`=0 immediately, with no clock edge needed.
- Prescaler, with `DOWN_COUNTER_PRESCALE_EN` and PRESCALE=4:
  - Stimulus: `data`=8'd2, `en`=1.
  - Response: `tc` arrives 8 cycles after the load edge; `count` changes every 4 cycles.
